// File: rtl/hms_time_counter.sv
// rtl/hms_time_counter.sv - BCD HH:MM:SS 24h counter with key-driven set mode; alarm built only when ALARM_EN is defined
module hms_time_counter #(
   parameter logic [7:0] INIT_HOUR  = 8'h00,
   parameter int         ALARM_SECS = 10
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       Tick,
   input  logic       ModeKey,
   input  logic       IncKey,
   output logic [7:0] Hour,
   output logic [7:0] Min,
   output logic [7:0] Sec,
   output logic [2:0] SetState,
   output logic       DayCarry,
   output logic       AlarmOut
);

   localparam logic [2:0] RUN    = 3'd0;
   localparam logic [2:0] SET_H  = 3'd1;
   localparam logic [2:0] SET_M  = 3'd2;
   localparam logic [2:0] SET_AH = 3'd3;
   localparam logic [2:0] SET_AM = 3'd4;

   logic [2:0] state, state_n;
   logic [7:0] hour_r, min_r, sec_r;
   logic [7:0] hour_n, min_n, sec_n;
   logic [7:0] disp_h, disp_m, disp_s;
   logic       day_n;
   logic       tick_ok;

   // Two-digit BCD increment that wraps to 00 after 'last'
   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
      if (v == last)
         bcd_inc = 8'h00;
      else if (v[3:0] == 4'd9)
         bcd_inc = {v[7:4] + 4'd1, 4'd0};
      else
         bcd_inc = {v[7:4], v[3:0] + 4'd1};
   endfunction

   // Tick only advances time outside the hour/minute set states
   assign tick_ok = Tick && (state != SET_H) && (state != SET_M);

   // Next time and mode: tick cascade first, then mode change or set-key increment
   always_comb begin
      state_n = state;
      hour_n  = hour_r;
      min_n   = min_r;
      sec_n   = sec_r;
      day_n   = 1'b0;
      if (tick_ok) begin
         sec_n = bcd_inc(sec_r, 8'h59);
         if (sec_r == 8'h59) begin
            min_n = bcd_inc(min_r, 8'h59);
            if (min_r == 8'h59) begin
               hour_n = bcd_inc(hour_r, 8'h23);
               day_n  = (hour_r == 8'h23);
            end
         end
      end
      if (ModeKey) begin
         case (state)
            RUN:     state_n = SET_H;
            SET_H:   state_n = SET_M;
            SET_M: begin
`ifdef ALARM_EN
               state_n = SET_AH;
`else
               state_n = RUN;
`endif
               sec_n = 8'h00;
            end
`ifdef ALARM_EN
            SET_AH:  state_n = SET_AM;
            SET_AM:  state_n = RUN;
`endif
            default: state_n = RUN;
         endcase
      end else if (IncKey) begin
         if (state == SET_H)
            hour_n = bcd_inc(hour_r, 8'h23);
         else if (state == SET_M)
            min_n = bcd_inc(min_r, 8'h59);
      end
   end

`ifdef ALARM_EN
   localparam logic [7:0] ALARM_LOAD = ALARM_SECS[7:0];

   logic [7:0] alarm_h, alarm_m, alarm_cnt;
   logic [7:0] alarm_h_n, alarm_m_n, alarm_cnt_n;
   logic       alarm_n;

   // Alarm register edits, trigger on an exact HH:MM:00 match, tick countdown, key cancel
   always_comb begin
      alarm_h_n   = alarm_h;
      alarm_m_n   = alarm_m;
      alarm_cnt_n = alarm_cnt;
      alarm_n     = AlarmOut;
      if (!ModeKey && IncKey) begin
         if (state == SET_AH)
            alarm_h_n = bcd_inc(alarm_h, 8'h23);
         else if (state == SET_AM)
            alarm_m_n = bcd_inc(alarm_m, 8'h59);
      end
      if (ModeKey || IncKey) begin
         alarm_n     = 1'b0;
         alarm_cnt_n = 8'd0;
      end else if (tick_ok && hour_n == alarm_h && min_n == alarm_m && sec_n == 8'h00) begin
         alarm_n     = 1'b1;
         alarm_cnt_n = ALARM_LOAD;
      end else if (tick_ok && AlarmOut) begin
         alarm_cnt_n = alarm_cnt - 8'd1;
         alarm_n     = (alarm_cnt != 8'd1);
      end
   end

   // Alarm state registers
   always_ff @(posedge Clk) begin
      if (Rst) begin
         alarm_h   <= 8'h00;
         alarm_m   <= 8'h00;
         alarm_cnt <= 8'd0;
         AlarmOut  <= 1'b0;
      end else begin
         alarm_h   <= alarm_h_n;
         alarm_m   <= alarm_m_n;
         alarm_cnt <= alarm_cnt_n;
         AlarmOut  <= alarm_n;
      end
   end

   // Alarm-set states show the alarm register with seconds blanked to 00
   always_comb begin
      if (state_n == SET_AH || state_n == SET_AM) begin
         disp_h = alarm_h_n;
         disp_m = alarm_m_n;
         disp_s = 8'h00;
      end else begin
         disp_h = hour_n;
         disp_m = min_n;
         disp_s = sec_n;
      end
   end
`else
   assign AlarmOut = 1'b0;

   // Without the alarm the display always shows the running time
   always_comb begin
      disp_h = hour_n;
      disp_m = min_n;
      disp_s = sec_n;
   end
`endif

   // Time, mode and registered display outputs
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state    <= RUN;
         hour_r   <= INIT_HOUR;
         min_r    <= 8'h00;
         sec_r    <= 8'h00;
         Hour     <= INIT_HOUR;
         Min      <= 8'h00;
         Sec      <= 8'h00;
         SetState <= RUN;
         DayCarry <= 1'b0;
      end else begin
         state    <= state_n;
         hour_r   <= hour_n;
         min_r    <= min_n;
         sec_r    <= sec_n;
         Hour     <= disp_h;
         Min      <= disp_m;
         Sec      <= disp_s;
         SetState <= state_n;
         DayCarry <= day_n;
      end
   end

endmodule

// File: tb/tb_hms_time_counter.sv
// tb/tb_hms_time_counter.sv - scoreboard bench for hms_time_counter (alarm scenario when ALARM_EN is defined)
module tb_hms_time_counter;

`ifdef ALARM_EN
   localparam bit HAS_ALARM = 1'b1;
`else
   localparam bit HAS_ALARM = 1'b0;
`endif

   logic       Clk = 1'b0;
   logic       Rst = 1'b1;
   logic       Tick = 1'b0;
   logic       ModeKey = 1'b0;
   logic       IncKey = 1'b0;
   logic [7:0] Hour, Min, Sec;
   logic [2:0] SetState;
   logic       DayCarry, AlarmOut;

   typedef struct {
      string       name;
      logic [29:0] v;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   total = 0;
   int   bad = 0;

   hms_time_counter dut (
      .Clk(Clk), .Rst(Rst), .Tick(Tick), .ModeKey(ModeKey), .IncKey(IncKey),
      .Hour(Hour), .Min(Min), .Sec(Sec), .SetState(SetState),
      .DayCarry(DayCarry), .AlarmOut(AlarmOut)
   );

   always #5 Clk = ~Clk;

   function automatic logic [29:0] pk(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                                      input logic [2:0] st, input logic dc, input logic al);
      return {h, m, s, st, dc, al};
   endfunction

   task automatic cyc(input logic t, input logic m, input logic i);
      Tick = t; ModeKey = m; IncKey = i;
      @(posedge Clk);
      #1;
      Tick = 1'b0; ModeKey = 1'b0; IncKey = 1'b0;
   endtask

   task automatic ticks(input int n);
      repeat (n) cyc(1'b1, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      Rst = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);
      Rst = 1'b0;
   endtask

   // From RUN at 00:00:00, dial in hh:mm:00 with the set keys and return to RUN
   task automatic set_time(input int nh, input int nm);
      cyc(1'b0, 1'b1, 1'b0);
      repeat (nh) cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 1'b0);
      repeat (nm) cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 1'b0);
      if (HAS_ALARM) begin
         cyc(1'b0, 1'b1, 1'b0);
         cyc(1'b0, 1'b1, 1'b0);
      end
   endtask

   task automatic test_reset();
      Rst = 1'b1;
      sb.push_back('{"rst_override", pk(8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0)});
      cyc(1'b1, 1'b1, 1'b1);
      e = sb.pop_front(); total++;
      if ({Hour, Min, Sec, SetState, DayCarry, AlarmOut} !== e.v) begin
         bad++; $display("FAIL %s got=%h want=%h", e.name, {Hour, Min, Sec, SetState, DayCarry, AlarmOut}, e.v);
      end
      cyc(1'b0, 1'b0, 1'b0);
      Rst = 1'b0;
      sb.push_back('{"rst_idle", pk(8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0)});
      cyc(1'b0, 1'b0, 1'b0);
      e = sb.pop_front(); total++;
      if ({Hour, Min, Sec, SetState, DayCarry, AlarmOut} !== e.v) begin
         bad++; $display("FAIL %s got=%h want=%h", e.name, {Hour, Min, Sec, SetState, DayCarry, AlarmOut}, e.v);
      end
   endtask

   task automatic test_day_rollover();
      do_reset();
      set_time(23, 59);
      sb.push_back('{"preload_235900", pk(8'h23, 8'h59, 8'h00, 3'd0, 1'b0, 1'b0)});
      sb.push_back('{"tick_235958", pk(8'h23, 8'h59, 8'h58, 3'd0, 1'b0, 1'b0)});
      sb.push_back('{"tick_235959", pk(8'h23, 8'h59, 8'h59, 3'd0, 1'b0, 1'b0)});
      sb.push_back('{"rollover_daycarry", pk(8'h00, 8'h00, 8'h00, 3'd0, 1'b1, HAS_ALARM)});
      sb.push_back('{"daycarry_one_cycle", pk(8'h00, 8'h00, 8'h00, 3'd0, 1'b0, HAS_ALARM)});
      for (int k = 0; k < 5; k++) begin
         if (k == 1) ticks(58);
         else if (k == 2 || k == 3) ticks(1);
         else if (k == 4) cyc(1'b0, 1'b0, 1'b0);
         e = sb.pop_front(); total++;
         if ({Hour, Min, Sec, SetState, DayCarry, AlarmOut} !== e.v) begin
            bad++; $display("FAIL %s got=%h want=%h", e.name, {Hour, Min, Sec, SetState, DayCarry, AlarmOut}, e.v);
         end
      end
   endtask

   task automatic test_set_mode();
      do_reset();
      set_time(12, 34);
      ticks(56);
      sb.push_back('{"run_123456", pk(8'h12, 8'h34, 8'h56, 3'd0, 1'b0, 1'b0)});
      sb.push_back('{"set_h_frozen", pk(8'h12, 8'h34, 8'h56, 3'd1, 1'b0, 1'b0)});
      sb.push_back('{"set_h_inc3", pk(8'h15, 8'h34, 8'h56, 3'd1, 1'b0, 1'b0)});
      sb.push_back('{"set_m_inc30", pk(8'h15, 8'h04, 8'h56, 3'd2, 1'b0, 1'b0)});
      sb.push_back('{"leave_set_m", HAS_ALARM ? pk(8'h00, 8'h00, 8'h00, 3'd3, 1'b0, 1'b0)
                                             : pk(8'h15, 8'h04, 8'h00, 3'd0, 1'b0, 1'b0)});
      for (int k = 0; k < 5; k++) begin
         if (k == 1) begin cyc(1'b0, 1'b1, 1'b0); ticks(5); end
         else if (k == 2) repeat (3) cyc(1'b0, 1'b0, 1'b1);
         else if (k == 3) begin cyc(1'b0, 1'b1, 1'b0); repeat (30) cyc(1'b0, 1'b0, 1'b1); end
         else if (k == 4) cyc(1'b0, 1'b1, 1'b0);
         e = sb.pop_front(); total++;
         if ({Hour, Min, Sec, SetState, DayCarry, AlarmOut} !== e.v) begin
            bad++; $display("FAIL %s got=%h want=%h", e.name, {Hour, Min, Sec, SetState, DayCarry, AlarmOut}, e.v);
         end
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      cyc(1'b0, 1'b1, 1'b0);
      repeat (9) cyc(1'b0, 1'b0, 1'b1);
      sb.push_back('{"mode_inc_same_cycle", pk(8'h09, 8'h00, 8'h00, 3'd2, 1'b0, 1'b0)});
      cyc(1'b0, 1'b1, 1'b1);
      e = sb.pop_front(); total++;
      if ({Hour, Min, Sec, SetState, DayCarry, AlarmOut} !== e.v) begin
         bad++; $display("FAIL %s got=%h want=%h", e.name, {Hour, Min, Sec, SetState, DayCarry, AlarmOut}, e.v);
      end
      do_reset();
      set_time(10, 0);
      ticks(5);
      sb.push_back('{"tick_mode_run", pk(8'h10, 8'h00, 8'h06, 3'd1, 1'b0, 1'b0)});
      cyc(1'b1, 1'b1, 1'b0);
      e = sb.pop_front(); total++;
      if ({Hour, Min, Sec, SetState, DayCarry, AlarmOut} !== e.v) begin
         bad++; $display("FAIL %s got=%h want=%h", e.name, {Hour, Min, Sec, SetState, DayCarry, AlarmOut}, e.v);
      end
   endtask

   task automatic test_alarm();
      do_reset();
      repeat (3) cyc(1'b0, 1'b1, 1'b0);
      sb.push_back('{"alarm_set_hour", pk(8'h07, 8'h00, 8'h00, 3'd3, 1'b0, 1'b0)});
      sb.push_back('{"alarm_set_min", pk(8'h07, 8'h30, 8'h00, 3'd4, 1'b0, 1'b0)});
      sb.push_back('{"alarm_back_run", pk(8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0)});
      sb.push_back('{"pre_alarm_072959", pk(8'h07, 8'h29, 8'h59, 3'd0, 1'b0, 1'b0)});
      sb.push_back('{"alarm_trigger", pk(8'h07, 8'h30, 8'h00, 3'd0, 1'b0, 1'b1)});
      sb.push_back('{"alarm_after_9", pk(8'h07, 8'h30, 8'h09, 3'd0, 1'b0, 1'b1)});
      sb.push_back('{"alarm_expire_10", pk(8'h07, 8'h30, 8'h10, 3'd0, 1'b0, 1'b0)});
      sb.push_back('{"alarm2_run", pk(8'h07, 8'h30, 8'h00, 3'd0, 1'b0, 1'b0)});
      sb.push_back('{"alarm2_trigger", pk(8'h07, 8'h31, 8'h00, 3'd0, 1'b0, 1'b1)});
      sb.push_back('{"alarm2_after_3", pk(8'h07, 8'h31, 8'h03, 3'd0, 1'b0, 1'b1)});
      sb.push_back('{"alarm2_inc_cancel", pk(8'h07, 8'h31, 8'h03, 3'd0, 1'b0, 1'b0)});
      for (int k = 0; k < 11; k++) begin
         case (k)
            0: repeat (7) cyc(1'b0, 1'b0, 1'b1);
            1: begin cyc(1'b0, 1'b1, 1'b0); repeat (30) cyc(1'b0, 1'b0, 1'b1); end
            2: cyc(1'b0, 1'b1, 1'b0);
            3: begin set_time(7, 29); ticks(59); end
            4: ticks(1);
            5: ticks(9);
            6: ticks(1);
            7: begin repeat (4) cyc(1'b0, 1'b1, 1'b0); cyc(1'b0, 1'b0, 1'b1); cyc(1'b0, 1'b1, 1'b0); end
            8: ticks(60);
            9: ticks(3);
            default: cyc(1'b0, 1'b0, 1'b1);
         endcase
         e = sb.pop_front(); total++;
         if ({Hour, Min, Sec, SetState, DayCarry, AlarmOut} !== e.v) begin
            bad++; $display("FAIL %s got=%h want=%h", e.name, {Hour, Min, Sec, SetState, DayCarry, AlarmOut}, e.v);
         end
      end
   endtask

   task automatic test_reset_in_set_m();
      do_reset();
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      repeat (45) cyc(1'b0, 1'b0, 1'b1);
      sb.push_back('{"set_m_min45", pk(8'h00, 8'h45, 8'h00, 3'd2, 1'b0, 1'b0)});
      sb.push_back('{"rst_mid_set_m", pk(8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0)});
      for (int k = 0; k < 2; k++) begin
         if (k == 1) begin
            Rst = 1'b1;
            cyc(1'b1, 1'b0, 1'b1);
            Rst = 1'b0;
         end
         e = sb.pop_front(); total++;
         if ({Hour, Min, Sec, SetState, DayCarry, AlarmOut} !== e.v) begin
            bad++; $display("FAIL %s got=%h want=%h", e.name, {Hour, Min, Sec, SetState, DayCarry, AlarmOut}, e.v);
         end
      end
   endtask

   initial begin
      test_reset();
      test_day_rollover();
      test_set_mode();
      test_simultaneous();
      if (HAS_ALARM) test_alarm();
      test_reset_in_set_m();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
